fiat_25519_carry_mul_carry_chain: RTL and testbench



---
 rtl/fiat_25519_pkg.sv | 30 +++
 rtl/fiat_25519_limb_split.sv | 18 +
 rtl/fiat_25519_carry_mul_carry_chain.sv | 124 ++++++++++++
 tb/tb_fiat_25519_carry_mul_carry_chain.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fiat_25519_pkg.sv
// Shared constants, types and helpers for the GF(2^255-19)
// carry chain that follows the carry_mul column accumulators.
package fiat_25519_pkg;

    localparam int NLIMBS    = 10;
    localparam int IN_WIDTH  = 64;
    localparam int OUT_WIDTH = 32;
    localparam int WRAP_MUL  = 19;
    localparam int CARRY_W   = 40;
    localparam int SUM_W     = IN_WIDTH + 1;
    localparam int LIMB_W    = 26;
    localparam int WRAP_W    = 47;
    localparam int IDX_W     = 4;

    localparam logic [LIMB_W-1:0] MASK26 = 26'h3ff_ffff;
    localparam logic [LIMB_W-1:0] MASK25 = 26'h1ff_ffff;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NLIMBS - 1);

    typedef enum logic [1:0] {
        ACCUM,
        WRAP,
        EMIT
    } state_e;

    // Radix 2^25.5: even limbs carry 26 bits, odd limbs 25.
    function automatic int unsigned limb_w(input int unsigned i);
        return (i % 2 == 0) ? 26 : 25;
    endfunction

endpackage

// File: rtl/fiat_25519_limb_split.sv
// Splits a wide sum into one limb and the carry that
// propagates into the next limb position.
module fiat_25519_limb_split
    import fiat_25519_pkg::*;
(
    input  logic [SUM_W-1:0]   s,
    input  logic               odd,
    output logic [LIMB_W-1:0]  limb,
    output logic [CARRY_W-1:0] carry
);

    // Mask to the limb width and shift the remainder down.
    always_comb begin
        limb  = s[LIMB_W-1:0] & (odd ? MASK25 : MASK26);
        carry = odd ? s[SUM_W-1:25] : {1'b0, s[SUM_W-1:26]};
    end

endmodule

// File: rtl/fiat_25519_carry_mul_carry_chain.sv
// Carry propagation with x19 wrap over ten column sums,
// buffered and streamed out as ten 32-bit reduced limbs.
module fiat_25519_carry_mul_carry_chain
    import fiat_25519_pkg::*;
(
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CARRY_W-1:0] carry_q, carry_d;
    logic [LIMB_W-1:0]  limb_q [NLIMBS];
    logic [LIMB_W-1:0]  limb_d [NLIMBS];

    logic [WRAP_W-1:0]  wrap_t;
    logic [SUM_W-1:0]   split_s;
    logic               split_odd;
    logic [LIMB_W-1:0]  split_limb;
    logic [CARRY_W-1:0] split_carry;

    // One splitter serves both the column carry and the wrap.
    always_comb begin
        wrap_t = WRAP_W'(limb_q[0])
               + WRAP_W'(carry_q) * WRAP_W'(WRAP_MUL);
        if (state_q == WRAP) begin
            split_s   = {{(SUM_W-WRAP_W){1'b0}}, wrap_t};
            split_odd = 1'b0;
        end else begin
            split_s   = {1'b0, in_data} + SUM_W'(carry_q);
            split_odd = idx_q[0];
        end
    end

    fiat_25519_limb_split u_split (
        .s     (split_s),
        .odd   (split_odd),
        .limb  (split_limb),
        .carry (split_carry)
    );

    // Next-state: accumulate, fold the top carry, then emit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        limb_d  = limb_q;
        unique case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    limb_d[idx_q] = split_limb;
                    carry_d       = split_carry;
                    if (idx_q == LAST_IDX) begin
                        state_d = WRAP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WRAP: begin
                limb_d[0] = split_limb;
                limb_d[1] = limb_q[1] + split_carry[LIMB_W-1:0];
                carry_d   = '0;
                state_d   = EMIT;
                idx_d     = '0;
            end
            EMIT: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ACCUM;
                        idx_d   = '0;
                        carry_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
                idx_d   = '0;
                carry_d = '0;
            end
        endcase
    end

    // State, index, carry and limb buffer registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= ACCUM;
            idx_q   <= '0;
            carry_q <= '0;
            for (int i = 0; i < NLIMBS; i++) begin
                limb_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            for (int i = 0; i < NLIMBS; i++) begin
                limb_q[i] <= limb_d[i];
            end
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == EMIT);
        out_last  = (state_q == EMIT) && (idx_q == LAST_IDX);
        out_data  = '0;
        if (state_q == EMIT) begin
            out_data = OUT_WIDTH'(limb_q[idx_q]);
        end
    end

endmodule

// File: tb/tb_fiat_25519_carry_mul_carry_chain.sv
// Scoreboard bench: driver queues expected limbs, a monitor
// pops and compares on every output handshake.
module tb_fiat_25519_carry_mul_carry_chain;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;

    int total = 0;
    int bad = 0;

    logic [32:0] sb_q[$];
    logic [63:0] op [10];
    logic [31:0] ex [10];

    always #5 ap_clk = ~ap_clk;

    fiat_25519_carry_mul_carry_chain dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", {31'b0, out_last, out_data}, 64'hdead);
            end else begin
                chk("out_beat", {31'b0, out_last, out_data},
                    {31'b0, sb_q.pop_front()});
            end
        end
    end

    task automatic push_exp();
        for (int i = 0; i < 10; i++) begin
            sb_q.push_back({(i == 9), ex[i]});
        end
    endtask

    task automatic set_zero();
        for (int i = 0; i < 10; i++) begin
            op[i] = '0;
            ex[i] = '0;
        end
    endtask

    task automatic send_op(input bit gaps);
        for (int i = 0; i < 10; i++) begin
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 64'hffff_ffff_ffff;
                repeat (2) @(posedge ap_clk);
                #1;
            end
            in_data  = op[i];
            in_valid = 1'b1;
            chk("in_ready_accum", {63'b0, in_ready}, 64'd1);
            @(posedge ap_clk);
            #1;
            in_valid = 1'b0;
            in_data  = '0;
        end
        chk("lat_wrap_no_valid", {63'b0, out_valid}, 64'd0);
        chk("lat_wrap_no_ready", {63'b0, in_ready}, 64'd0);
        @(posedge ap_clk);
        #1;
        chk("lat_emit_valid", {63'b0, out_valid}, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge ap_clk);
            n++;
        end
        #1;
        chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        chk("back_to_accum", {63'b0, in_ready}, 64'd1);
        chk("idle_no_valid", {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_last", {63'b0, out_last}, 64'd0);
        chk("rst_out_data", {32'b0, out_data}, 64'd0);
        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // all zeros
        set_zero();
        push_exp();
        send_op(1'b0);
        drain();

        // 2^26 into limb 0 carries one into limb 1
        set_zero();
        op[0] = 64'd1 << 26;
        ex[1] = 32'd1;
        push_exp();
        send_op(1'b0);
        drain();

        // 2^25 into limb 9 wraps as 19 into limb 0
        set_zero();
        op[9] = 64'd1 << 25;
        ex[0] = 32'd19;
        push_exp();
        send_op(1'b0);
        drain();

        // full ripple, with input gaps
        set_zero();
        op[0] = (64'd1 << 27) - 1;
        for (int i = 1; i < 10; i++) begin
            op[i] = (i % 2 == 0) ? (64'd1 << 26) - 1 : (64'd1 << 25) - 1;
        end
        ex[0] = 32'd18;
        ex[1] = 32'd1;
        push_exp();
        send_op(1'b1);
        drain();

        // small distinct values, stall at index 4
        for (int i = 0; i < 10; i++) begin
            op[i] = 64'(i + 1);
            ex[i] = 32'(i + 1);
        end
        push_exp();
        out_ready = 1'b0;
        send_op(1'b0);
        out_ready = 1'b1;
        repeat (4) @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge ap_clk);
            #1;
            chk("stall_data", {32'b0, out_data}, 64'd5);
            chk("stall_valid", {63'b0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        drain();

        // reset while emitting index 6
        set_zero();
        op[0] = 64'h3ff_ffff;
        op[3] = 64'h123_4567;
        op[6] = 64'h0ab_cdef;
        for (int i = 0; i < 10; i++) begin
            ex[i] = 32'(op[i]);
        end
        push_exp();
        send_op(1'b0);
        repeat (6) @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        chk("pre_rst_last", {63'b0, out_last}, 64'd0);
        chk("pre_rst_data", {32'b0, out_data}, 64'h0ab_cdef);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("arst_out_data", {32'b0, out_data}, 64'd0);
        sb_q.delete();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;

        // zero operand after abort leaves no residue
        set_zero();
        push_exp();
        send_op(1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
